// File: rtl/fetch_pc_stage.sv
// Y86-64 fetch-side state: the F predicted-PC register, fetch-address selection
// (mispredict and ret recovery override the prediction), and the F->D pipeline register.
module fetch_pc_stage #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter logic [3:0]  NOP_ICODE = 4'h1,
  parameter logic [3:0]  RNONE     = 4'hF,
  parameter logic [2:0]  STAT_AOK  = 3'd1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] predPC,
  input  logic [3:0]  M_icode,
  input  logic        M_cnd,
  input  logic [63:0] M_valA,
  input  logic [3:0]  W_icode,
  input  logic [63:0] W_valM,
  input  logic        F_stall,
  input  logic        D_stall,
  input  logic        D_bubble,
  input  logic [3:0]  f_icode,
  input  logic [3:0]  f_ifun,
  input  logic [3:0]  f_rA,
  input  logic [3:0]  f_rB,
  input  logic [63:0] f_valC,
  input  logic [63:0] f_valP,
  input  logic [2:0]  f_stat,
  output logic [63:0] f_pc,
  output logic [63:0] F_predPC,
  output logic [3:0]  D_icode,
  output logic [3:0]  D_ifun,
  output logic [3:0]  D_rA,
  output logic [3:0]  D_rB,
  output logic [63:0] D_valC,
  output logic [63:0] D_valP,
  output logic [63:0] D_pc,
  output logic [2:0]  D_stat,
  output logic        D_valid
);

  localparam logic [3:0] IJXX = 4'h7;
  localparam logic [3:0] IRET = 4'h9;

  logic [63:0] f_predpc_q;
  logic [3:0]  d_icode_q, d_icode_d;
  logic [3:0]  d_ifun_q,  d_ifun_d;
  logic [3:0]  d_ra_q,    d_ra_d;
  logic [3:0]  d_rb_q,    d_rb_d;
  logic [63:0] d_valc_q,  d_valc_d;
  logic [63:0] d_valp_q,  d_valp_d;
  logic [63:0] d_pc_q,    d_pc_d;
  logic [2:0]  d_stat_q,  d_stat_d;
  logic        d_valid_q, d_valid_d;

  // Fetch address: a not-taken jXX in M beats a ret in W, which beats the prediction.
  always_comb begin
    f_pc = f_predpc_q;
    if ((M_icode == IJXX) && !M_cnd) begin
      f_pc = M_valA;
    end else if (W_icode == IRET) begin
      f_pc = W_valM;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_predpc_q <= RESET_PC;
    end else if (!F_stall) begin
      f_predpc_q <= predPC;
    end
  end

  // Stall has precedence over bubble.
  always_comb begin
    d_icode_d = d_icode_q;
    d_ifun_d  = d_ifun_q;
    d_ra_d    = d_ra_q;
    d_rb_d    = d_rb_q;
    d_valc_d  = d_valc_q;
    d_valp_d  = d_valp_q;
    d_pc_d    = d_pc_q;
    d_stat_d  = d_stat_q;
    d_valid_d = d_valid_q;
    if (!D_stall) begin
      if (D_bubble) begin
        d_icode_d = NOP_ICODE;
        d_ifun_d  = 4'h0;
        d_ra_d    = RNONE;
        d_rb_d    = RNONE;
        d_valc_d  = 64'h0;
        d_valp_d  = 64'h0;
        d_pc_d    = 64'h0;
        d_stat_d  = STAT_AOK;
        d_valid_d = 1'b0;
      end else begin
        d_icode_d = f_icode;
        d_ifun_d  = f_ifun;
        d_ra_d    = f_rA;
        d_rb_d    = f_rB;
        d_valc_d  = f_valC;
        d_valp_d  = f_valP;
        d_pc_d    = f_pc;
        d_stat_d  = f_stat;
        d_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_icode_q <= NOP_ICODE;
      d_ifun_q  <= 4'h0;
      d_ra_q    <= RNONE;
      d_rb_q    <= RNONE;
      d_valc_q  <= 64'h0;
      d_valp_q  <= 64'h0;
      d_pc_q    <= 64'h0;
      d_stat_q  <= STAT_AOK;
      d_valid_q <= 1'b0;
    end else begin
      d_icode_q <= d_icode_d;
      d_ifun_q  <= d_ifun_d;
      d_ra_q    <= d_ra_d;
      d_rb_q    <= d_rb_d;
      d_valc_q  <= d_valc_d;
      d_valp_q  <= d_valp_d;
      d_pc_q    <= d_pc_d;
      d_stat_q  <= d_stat_d;
      d_valid_q <= d_valid_d;
    end
  end

  assign F_predPC = f_predpc_q;
  assign D_icode  = d_icode_q;
  assign D_ifun   = d_ifun_q;
  assign D_rA     = d_ra_q;
  assign D_rB     = d_rb_q;
  assign D_valC   = d_valc_q;
  assign D_valP   = d_valp_q;
  assign D_pc     = d_pc_q;
  assign D_stat   = d_stat_q;
  assign D_valid  = d_valid_q;

endmodule

// File: tb/tb_fetch_pc_stage.sv
// Scoreboard bench for fetch_pc_stage: directed recovery/stall/reset cases plus random traffic.
module tb_fetch_pc_stage;

  typedef struct packed {
    logic [3:0]  icode, ifun, ra, rb;
    logic [63:0] valc, valp, pc;
    logic [2:0]  stat;
    logic        valid;
  } dreg_t;

  typedef struct packed {
    logic [63:0] pred_pc;
    logic [3:0]  m_icode;
    logic        m_cnd;
    logic [63:0] m_vala;
    logic [3:0]  w_icode;
    logic [63:0] w_valm;
    logic        f_stall, d_stall, d_bubble;
    logic [3:0]  icode, ifun, ra, rb;
    logic [63:0] valc, valp;
    logic [2:0]  stat;
  } in_t;

  typedef struct packed {
    logic [63:0] fpc;
    logic [63:0] predpc;
    dreg_t       d;
  } rec_t;

  localparam dreg_t BUBBLE = '{icode: 4'h1, ifun: 4'h0, ra: 4'hF, rb: 4'hF,
                               valc: 64'h0, valp: 64'h0, pc: 64'h0, stat: 3'd1, valid: 1'b0};

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] predPC, M_valA, W_valM, f_valC, f_valP;
  logic [3:0]  M_icode, W_icode, f_icode, f_ifun, f_rA, f_rB;
  logic        M_cnd, F_stall, D_stall, D_bubble;
  logic [2:0]  f_stat;
  logic [63:0] f_pc, F_predPC, D_valC, D_valP, D_pc;
  logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
  logic [2:0]  D_stat;
  logic        D_valid;

  fetch_pc_stage dut (
    .clk(clk), .rst_n(rst_n), .predPC(predPC), .M_icode(M_icode), .M_cnd(M_cnd),
    .M_valA(M_valA), .W_icode(W_icode), .W_valM(W_valM), .F_stall(F_stall),
    .D_stall(D_stall), .D_bubble(D_bubble), .f_icode(f_icode), .f_ifun(f_ifun),
    .f_rA(f_rA), .f_rB(f_rB), .f_valC(f_valC), .f_valP(f_valP), .f_stat(f_stat),
    .f_pc(f_pc), .F_predPC(F_predPC), .D_icode(D_icode), .D_ifun(D_ifun),
    .D_rA(D_rA), .D_rB(D_rB), .D_valC(D_valC), .D_valP(D_valP), .D_pc(D_pc),
    .D_stat(D_stat), .D_valid(D_valid)
  );

  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_fail   = 0;
  rec_t  sb_q[$];
  rec_t  mon_r;
  logic [63:0] m_pred;
  dreg_t       m_d;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: which address is fetched, written as the recovery rules.
  function automatic logic [63:0] ref_fpc(input in_t x, input logic [63:0] pred);
    logic mispredict, ret_pending;
    mispredict  = (x.m_icode == 4'd7) && (x.m_cnd == 1'b0);
    ret_pending = (x.w_icode == 4'd9);
    return mispredict ? x.m_vala : (ret_pending ? x.w_valm : pred);
  endfunction

  function automatic in_t idle_in();
    in_t x;
    x = '0;
    x.stat = 3'd1;
    return x;
  endfunction

  function automatic in_t rand_in();
    in_t x;
    x.pred_pc  = {$urandom(), $urandom()};
    x.m_icode  = ($urandom_range(0, 2) == 0) ? 4'd7 : 4'($urandom_range(0, 15));
    x.m_cnd    = 1'($urandom_range(0, 1));
    x.m_vala   = {$urandom(), $urandom()};
    x.w_icode  = ($urandom_range(0, 2) == 0) ? 4'd9 : 4'($urandom_range(0, 15));
    x.w_valm   = {$urandom(), $urandom()};
    x.f_stall  = ($urandom_range(0, 3) == 0);
    x.d_stall  = ($urandom_range(0, 3) == 0);
    x.d_bubble = ($urandom_range(0, 3) == 0);
    x.icode    = 4'($urandom_range(0, 15));
    x.ifun     = 4'($urandom_range(0, 15));
    x.ra       = 4'($urandom_range(0, 15));
    x.rb       = 4'($urandom_range(0, 15));
    x.valc     = {$urandom(), $urandom()};
    x.valp     = {$urandom(), $urandom()};
    x.stat     = 3'($urandom_range(0, 7));
    return x;
  endfunction

  // Drive one cycle's inputs, record what the monitor must see this cycle, advance the model.
  task automatic apply(input in_t x);
    rec_t  r;
    logic [63:0] fpc;
    predPC = x.pred_pc; M_icode = x.m_icode; M_cnd = x.m_cnd; M_valA = x.m_vala;
    W_icode = x.w_icode; W_valM = x.w_valm; F_stall = x.f_stall; D_stall = x.d_stall;
    D_bubble = x.d_bubble; f_icode = x.icode; f_ifun = x.ifun; f_rA = x.ra; f_rB = x.rb;
    f_valC = x.valc; f_valP = x.valp; f_stat = x.stat;
    fpc = ref_fpc(x, m_pred);
    r.fpc = fpc; r.predpc = m_pred; r.d = m_d;
    sb_q.push_back(r);
    if (!x.f_stall) m_pred = x.pred_pc;
    if (!x.d_stall) begin
      if (x.d_bubble) m_d = BUBBLE;
      else m_d = '{icode: x.icode, ifun: x.ifun, ra: x.ra, rb: x.rb, valc: x.valc,
                   valp: x.valp, pc: fpc, stat: x.stat, valid: 1'b1};
    end
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      mon_r = sb_q.pop_front();
      chk("f_pc", f_pc, mon_r.fpc);
      chk("F_predPC", F_predPC, mon_r.predpc);
      chk("D_icode", 64'(D_icode), 64'(mon_r.d.icode));
      chk("D_ifun", 64'(D_ifun), 64'(mon_r.d.ifun));
      chk("D_rA", 64'(D_rA), 64'(mon_r.d.ra));
      chk("D_rB", 64'(D_rB), 64'(mon_r.d.rb));
      chk("D_valC", D_valC, mon_r.d.valc);
      chk("D_valP", D_valP, mon_r.d.valp);
      chk("D_pc", D_pc, mon_r.d.pc);
      chk("D_stat", 64'(D_stat), 64'(mon_r.d.stat));
      chk("D_valid", 64'(D_valid), 64'(mon_r.d.valid));
    end
  end

  initial begin
    in_t x;
    logic [63:0] saved_pred;
    dreg_t       saved_d;

    rst_n = 1'b0;
    m_pred = 64'h0;
    m_d = BUBBLE;
    x = idle_in();
    predPC = 0; M_icode = 0; M_cnd = 0; M_valA = 0; W_icode = 0; W_valM = 0;
    F_stall = 0; D_stall = 0; D_bubble = 0; f_icode = 0; f_ifun = 0; f_rA = 0; f_rB = 0;
    f_valC = 0; f_valP = 0; f_stat = 0;
    #12;
    chk("rst F_predPC", F_predPC, 64'h0);
    chk("rst D_icode", 64'(D_icode), 64'h1);
    chk("rst D_valid", 64'(D_valid), 64'h0);
    chk("rst f_pc", f_pc, 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Sequential fetch.
    x = idle_in(); x.pred_pc = 64'h0A; x.icode = 4'h3; x.valc = 64'h55;
    apply(x); step();
    x = idle_in(); x.pred_pc = 64'h0B;
    apply(x);
    chk("seq F_predPC", F_predPC, 64'h0A);
    chk("seq f_pc", f_pc, 64'h0A);
    chk("seq D_icode", 64'(D_icode), 64'h3);
    chk("seq D_valC", D_valC, 64'h55);
    chk("seq D_pc", D_pc, 64'h0);
    chk("seq D_valid", 64'(D_valid), 64'h1);
    step();

    // Mispredict beats ret.
    x = idle_in(); x.pred_pc = 64'h40;
    apply(x); step();
    x = idle_in(); x.pred_pc = 64'h48; x.m_icode = 4'd7; x.m_cnd = 1'b0; x.m_vala = 64'h1B;
    x.w_icode = 4'd9; x.w_valm = 64'h300;
    apply(x);
    chk("mispredict f_pc", f_pc, 64'h1B);
    step();

    // Ret override, including when a taken jXX sits in M.
    x = idle_in(); x.m_icode = 4'd6; x.w_icode = 4'd9; x.w_valm = 64'h200;
    apply(x);
    chk("ret f_pc", f_pc, 64'h200);
    step();
    x.m_icode = 4'd7; x.m_cnd = 1'b1; x.m_vala = 64'h99;
    apply(x);
    chk("ret taken-jxx f_pc", f_pc, 64'h200);
    step();

    // Codes 0xC-0xF select the prediction.
    x = idle_in(); x.m_icode = 4'hC; x.w_icode = 4'hF; x.m_vala = 64'h1; x.w_valm = 64'h2;
    apply(x);
    chk("no-override f_pc", f_pc, m_pred_before(x));
    step();

    // Both stalled for three cycles with changing inputs.
    saved_pred = m_pred; saved_d = m_d;
    for (int i = 0; i < 3; i++) begin
      x = rand_in(); x.f_stall = 1'b1; x.d_stall = 1'b1;
      apply(x); step();
    end
    chk("stall F_predPC", F_predPC, saved_pred);
    chk("stall D_valC", D_valC, saved_d.valc);
    chk("stall D_pc", D_pc, saved_d.pc);

    x = rand_in(); x.f_stall = 1'b0; x.d_stall = 1'b0; x.d_bubble = 1'b1;
    apply(x); step();
    chk("bubble D_icode", 64'(D_icode), 64'h1);
    chk("bubble D_valid", 64'(D_valid), 64'h0);

    x = idle_in(); x.icode = 4'h6; x.ra = 4'h2;
    apply(x); step();
    saved_d = m_d;
    x = rand_in(); x.d_stall = 1'b1; x.d_bubble = 1'b1;
    apply(x); step();
    chk("stall+bubble D_icode", 64'(D_icode), 64'h6);
    chk("stall+bubble D_valid", 64'(D_valid), 64'h1);

    // Asynchronous reset mid-cycle while D holds icode 6.
    x = idle_in(); x.icode = 4'h6; x.pred_pc = 64'h123;
    apply(x); step();
    #2;
    chk("pre-rst D_icode", 64'(D_icode), 64'h6);
    rst_n = 1'b0;
    #1;
    m_pred = 64'h0; m_d = BUBBLE;
    chk("async D_icode", 64'(D_icode), 64'h1);
    chk("async D_rA", 64'(D_rA), 64'hF);
    chk("async D_rB", 64'(D_rB), 64'hF);
    chk("async D_valid", 64'(D_valid), 64'h0);
    chk("async D_stat", 64'(D_stat), 64'h1);
    chk("async F_predPC", F_predPC, 64'h0);
    chk("async f_pc", f_pc, 64'h0);
    W_icode = 4'd9; W_valM = 64'h77;
    #1;
    chk("rst ret f_pc", f_pc, 64'h77);
    @(posedge clk); #1;
    chk("rst held D_valid", 64'(D_valid), 64'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 400; i++) begin
      apply(rand_in());
      step();
    end
    apply(idle_in());

    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
    #1;
    if (sb_q.size() != 0) chk("scoreboard drain", 64'(sb_q.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Prediction register value in effect for the cycle just applied (model already advanced).
  function automatic logic [63:0] m_pred_before(input in_t x);
    return sb_q.size() != 0 ? sb_q[sb_q.size()-1].predpc : 64'h0;
  endfunction

endmodule
